// File: rtl/motor_seq_pkg.sv
// Shared state encoding for the motor command sequencer.
// No logic; imported by the sequencer top.
package motor_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_DISABLED = 3'd0,
        SEQ_RUN      = 3'd1,
        SEQ_RAMPDOWN = 3'd2,
        SEQ_DWELL    = 3'd3,
        SEQ_BRAKE    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/pwm_slew_limiter.sv
// Saturating one-step move of a PWM value toward a target.
// Latency: combinational. Backpressure: none (pure function of inputs).
// A zero step bypasses the limit and returns the target regardless of tick.
module pwm_slew_limiter #(
    parameter int K_RES = 10
) (
    input  logic [K_RES-1:0] i_cur,
    input  logic [K_RES-1:0] i_target,
    input  logic [K_RES-1:0] i_step,
    input  logic             i_tick,
    output logic [K_RES-1:0] o_next
);

    logic [K_RES:0] cur_ext;
    logic [K_RES:0] tgt_ext;
    logic [K_RES:0] step_ext;
    logic [K_RES:0] up_sum;
    logic [K_RES:0] dn_floor;

    always_comb begin
        cur_ext  = {1'b0, i_cur};
        tgt_ext  = {1'b0, i_target};
        step_ext = {1'b0, i_step};
        up_sum   = cur_ext + step_ext;
        // Going down: cur-step stays above target iff cur >= target+step.
        dn_floor = tgt_ext + step_ext;
        o_next   = i_cur;
        if (i_step == '0) begin
            o_next = i_target;
        end else if (i_tick) begin
            if (cur_ext < tgt_ext) begin
                o_next = (up_sum >= tgt_ext) ? i_target : up_sum[K_RES-1:0];
            end else if (cur_ext > tgt_ext) begin
                o_next = (cur_ext >= dn_floor) ? (i_cur - i_step) : i_target;
            end
        end
    end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Slew-limits the PWM command and sequences safe direction flips (rampdown, brake dwell, flip).
// Latency: 1 cycle, all outputs registered. Backpressure: none, commands are sampled every cycle.
// Priority: disable > brake > direction change > slew.
module motor_cmd_sequencer
    import motor_seq_pkg::*;
#(
    parameter int K_PWMRES = 10,
    parameter int K_DWELLW = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_tick,
    input  logic                i_enable,
    input  logic [K_PWMRES-1:0] i_cmd_power,
    input  logic                i_cmd_rev,
    input  logic                i_cmd_brake,
    input  logic [K_PWMRES-1:0] i_param_ramp_step,
    input  logic [K_DWELLW-1:0] i_param_dwell,
    output logic [K_PWMRES-1:0] o_pwm_command,
    output logic                o_reverse,
    output logic                o_brake,
    output logic [2:0]          o_state,
    output logic                o_busy
);

    localparam logic [K_DWELLW-1:0] CNT_ONE = K_DWELLW'(1);

    seq_state_t          state_q, state_d;
    logic [K_PWMRES-1:0] pwm_q, pwm_d;
    logic                rev_q, rev_d;
    logic                brake_q, brake_d;
    logic                busy_q;
    logic [K_DWELLW-1:0] cnt_q, cnt_d;
    logic [K_PWMRES-1:0] slew_target;
    logic [K_PWMRES-1:0] slew_next;

    assign slew_target = (state_q == SEQ_RAMPDOWN) ? '0 : i_cmd_power;

    pwm_slew_limiter #(.K_RES(K_PWMRES)) u_slew (
        .i_cur    (pwm_q),
        .i_target (slew_target),
        .i_step   (i_param_ramp_step),
        .i_tick   (i_tick),
        .o_next   (slew_next)
    );

    always_comb begin
        state_d = state_q;
        pwm_d   = pwm_q;
        rev_d   = rev_q;
        brake_d = brake_q;
        cnt_d   = cnt_q;
        if (!i_enable) begin
            state_d = SEQ_DISABLED;
            pwm_d   = '0;
            brake_d = 1'b0;
        end else if (i_cmd_brake) begin
            state_d = SEQ_BRAKE;
            pwm_d   = '0;
            brake_d = 1'b1;
        end else begin
            case (state_q)
                SEQ_DISABLED, SEQ_BRAKE: begin
                    state_d = SEQ_RUN;
                    pwm_d   = '0;
                    brake_d = 1'b0;
                end
                SEQ_RUN: begin
                    if (i_cmd_rev != rev_q) begin
                        if (pwm_q != '0) begin
                            state_d = SEQ_RAMPDOWN;
                        end else begin
                            state_d = SEQ_DWELL;
                            brake_d = 1'b1;
                            cnt_d   = i_param_dwell;
                        end
                    end else begin
                        pwm_d = slew_next;
                    end
                end
                SEQ_RAMPDOWN: begin
                    if (i_cmd_rev == rev_q) begin
                        state_d = SEQ_RUN;
                    end else if (pwm_q == '0) begin
                        state_d = SEQ_DWELL;
                        brake_d = 1'b1;
                        cnt_d   = i_param_dwell;
                    end else begin
                        pwm_d = slew_next;
                    end
                end
                SEQ_DWELL: begin
                    if (i_cmd_rev == rev_q) begin
                        state_d = SEQ_RUN;
                        brake_d = 1'b0;
                    end else if (cnt_q == '0) begin
                        state_d = SEQ_RUN;
                        rev_d   = i_cmd_rev;
                        brake_d = 1'b0;
                    end else if (i_tick) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = SEQ_DISABLED;
                    pwm_d   = '0;
                    brake_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SEQ_DISABLED;
            pwm_q   <= '0;
            rev_q   <= 1'b0;
            brake_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pwm_q   <= pwm_d;
            rev_q   <= rev_d;
            brake_q <= brake_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == SEQ_RAMPDOWN) || (state_d == SEQ_DWELL);
        end
    end

    assign o_pwm_command = pwm_q;
    assign o_reverse     = rev_q;
    assign o_brake       = brake_q;
    assign o_state       = state_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Scoreboarded bench: a behavioural model pushes expected outputs each edge, a monitor compares.
module tb_motor_cmd_sequencer;

    localparam int PW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          en = 1'b0;
    logic [PW-1:0] cpow = '0;
    logic          crev = 1'b0;
    logic          cbrk = 1'b0;
    logic [PW-1:0] step = '0;
    logic [DW-1:0] dwell = '0;
    logic [PW-1:0] pwm;
    logic          rev;
    logic          brk;
    logic [2:0]    st;
    logic          busy;

    always #5 clk = ~clk;

    motor_cmd_sequencer #(.K_PWMRES(PW), .K_DWELLW(DW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_tick            (tick),
        .i_enable          (en),
        .i_cmd_power       (cpow),
        .i_cmd_rev         (crev),
        .i_cmd_brake       (cbrk),
        .i_param_ramp_step (step),
        .i_param_dwell     (dwell),
        .o_pwm_command     (pwm),
        .o_reverse         (rev),
        .o_brake           (brk),
        .o_state           (st),
        .o_busy            (busy)
    );

    typedef struct {
        int pwm;
        bit rev;
        bit brk;
        int st;
        bit busy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   tcnt = 0;
    bit   done = 1'b0;

    // Model mode numbers follow the documented status encoding.
    int m_mode = 0;
    int m_pwm = 0;
    int m_cnt = 0;
    bit m_rev = 1'b0;
    bit m_brk = 1'b0;

    function automatic int toward(int cur, int tgt, int stp, bit tk);
        if (stp == 0) return tgt;
        if (!tk) return cur;
        if (cur < tgt) return (cur + stp > tgt) ? tgt : cur + stp;
        if (cur > tgt) return (cur - stp < tgt) ? tgt : cur - stp;
        return cur;
    endfunction

    task automatic model_edge();
        int nm, np, nc;
        bit nr, nb;
        exp_t e;
        nm = m_mode; np = m_pwm; nc = m_cnt; nr = m_rev; nb = m_brk;
        if (!rst_n) begin
            nm = 0; np = 0; nc = 0; nr = 0; nb = 0;
        end else if (!en) begin
            nm = 0; np = 0; nb = 0;
        end else if (cbrk) begin
            nm = 4; np = 0; nb = 1;
        end else if (m_mode == 0 || m_mode == 4) begin
            nm = 1; np = 0; nb = 0;
        end else if (m_mode == 1) begin
            if (crev != m_rev) begin
                if (m_pwm != 0) nm = 2;
                else begin nm = 3; nb = 1; nc = int'(dwell); end
            end else np = toward(m_pwm, int'(cpow), int'(step), tick);
        end else if (m_mode == 2) begin
            if (crev == m_rev) nm = 1;
            else if (m_pwm == 0) begin nm = 3; nb = 1; nc = int'(dwell); end
            else np = toward(m_pwm, 0, int'(step), tick);
        end else begin
            if (crev == m_rev) begin nm = 1; nb = 0; end
            else if (m_cnt == 0) begin nm = 1; nr = crev; nb = 0; end
            else if (tick) nc = m_cnt - 1;
        end
        m_mode = nm; m_pwm = np; m_cnt = nc; m_rev = nr; m_brk = nb;
        e.pwm = np; e.rev = nr; e.brk = nb; e.st = nm; e.busy = (nm == 2 || nm == 3);
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (!done) model_edge();
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!done) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = q.pop_front();
                if (int'(pwm) != e.pwm || rev != e.rev || brk != e.brk ||
                    int'(st) != e.st || busy != e.busy) begin
                    failures++;
                    $display("FAIL outputs t=%0t got pwm=%0d rev=%0b brk=%0b st=%0d busy=%0b exp pwm=%0d rev=%0b brk=%0b st=%0d busy=%0b",
                             $time, pwm, rev, brk, st, busy, e.pwm, e.rev, e.brk, e.st, e.busy);
                end
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = (tcnt % 4 == 3);
            tcnt++;
        end
    endtask

    initial begin
        cycles(3);
        rst_n = 1'b1;
        // Ramp up 0 -> 1000 in steps of 100
        en = 1; step = 100; dwell = 5; cpow = 0; crev = 0; cbrk = 0;
        cycles(4);
        cpow = 1000;
        cycles(48);
        // Retarget down to 300, then a full direction flip with dwell 5
        cpow = 300;
        cycles(40);
        crev = 1;
        cycles(60);
        // Brake while ramping
        cpow = 1000;
        cycles(10);
        cbrk = 1;
        cycles(3);
        cbrk = 0;
        cycles(20);
        // Unlimited slew and top-of-range saturation
        step = 0; cpow = 0;
        cycles(2);
        cpow = 1023;
        cycles(2);
        step = 100; cpow = 1000;
        cycles(2);
        cpow = 1023;
        cycles(8);
        // Abort during rampdown
        crev = 0;
        cycles(6);
        crev = 1;
        cycles(4);
        // Abort during dwell, then a zero-length dwell
        cpow = 0;
        cycles(50);
        crev = 0;
        cycles(6);
        crev = 1;
        cycles(4);
        dwell = 0; crev = 0;
        cycles(4);
        // Async reset in the middle of a long dwell
        dwell = 20; crev = 1;
        cycles(6);
        rst_n = 0;
        #1;
        checks++;
        if (pwm != '0 || rev != 1'b0 || brk != 1'b0 || st != 3'd0 || busy != 1'b0) begin
            failures++;
            $display("FAIL async_reset got pwm=%0d rev=%0b brk=%0b st=%0d busy=%0b exp all zero",
                     pwm, rev, brk, st, busy);
        end
        cycles(2);
        rst_n = 1;
        // Disable while running at 700
        crev = 0; step = 100; cpow = 700;
        cycles(40);
        en = 0;
        cycles(2);
        en = 1;
        cycles(4);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) cpow = PW'($urandom_range(0, 1023));
            if ($urandom_range(0, 39) == 0) crev = ~crev;
            if ($urandom_range(0, 59) == 0) cbrk = ~cbrk;
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 4))
                    0: step = 0;
                    1: step = 1;
                    2: step = 37;
                    3: step = 100;
                    default: step = 1023;
                endcase
            end
            if ($urandom_range(0, 79) == 0) dwell = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 999) == 0) rst_n = 0;
            else rst_n = 1;
            cycles(1);
        end
        cycles(2);
        done = 1'b1;
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
